// File: rtl/rca_seq_ctrl.sv
// Nibble-serial adder sequencer: one shared 4-bit ripple-carry adder computes a WIDTH-bit
// sum over WIDTH/4 clocks, LSB nibble first, with the inter-nibble carry held in a flop.
module rca_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q,   state_d;
    logic [IdxW-1:0]  idx_q,     idx_d;
    logic             carry_q,   carry_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             cout_q,    cout_d;

    logic [3:0] rca_a;
    logic [3:0] rca_b;
    logic [3:0] rca_s;
    logic       rca_co;
    logic       rca_c;

    // Shared 4-bit ripple-carry adder fed by the current nibble and the registered carry.
    always_comb begin
        rca_a = a_q[4*idx_q +: 4];
        rca_b = b_q[4*idx_q +: 4];
        rca_s = 4'b0;
        rca_c = carry_q;
        for (int i = 0; i < 4; i++) begin
            rca_s[i] = rca_a[i] ^ rca_b[i] ^ rca_c;
            rca_c    = (rca_a[i] & rca_b[i]) | (rca_c & (rca_a[i] ^ rca_b[i]));
        end
        rca_co = rca_c;
    end

    // Next-state logic: accept in idle, one nibble per run cycle, single done cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        partial_d = partial_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    idx_d     = '0;
                    partial_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                partial_d[4*idx_q +: 4] = rca_s;
                carry_d                 = rca_co;
                if (idx_q == LastIdx) begin
                    // Result registers see only the fully assembled sum.
                    sum_d   = partial_d;
                    cout_d  = rca_co;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    // Status and result outputs decode straight from registers.
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Randomised bench for rca_seq_ctrl at WIDTH=16 and WIDTH=4 against an arithmetic model.
module tb_rca_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r16, s16, c16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;
    logic        r4, s4, c4, busy4, done4, cout4;
    logic [3:0]  a4, b4, sum4;

    rca_seq_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(r16), .start(s16), .a(a16), .b(b16), .cin(c16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    rca_seq_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(r4), .start(s4), .a(a4), .b(b4), .cin(c4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [16:0] last16 = '0;
    logic [4:0]  last4  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One add on the 16-bit instance; optional start pulse while it is in the third run cycle.
    task automatic do_add16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                            input bit inject);
        logic [16:0] exp;
        int lat, bcnt;
        bit seen;
        exp = 17'(av) + 17'(bv) + 17'(cv);
        a16 = av; b16 = bv; c16 = cv; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        lat = -1; bcnt = 0; seen = 1'b0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clk);
            if (inject && k == 3) begin s16 = 1'b1; a16 = 16'h0F0F; end
            if (inject && k == 4) s16 = 1'b0;
            if (busy16) bcnt++;
            if (done16) begin
                seen = 1'b1;
                lat  = k - 1;
            end else begin
                check("hold16", 32'({cout16, sum16}), 32'(last16));
            end
        end
        check("done16_seen", 32'(seen), 32'd1);
        check("lat16", 32'(lat), 32'd4);
        check("busy16_cycles", 32'(bcnt), 32'd5);
        check("sum16", 32'({cout16, sum16}), 32'(exp));
        last16 = exp;
        @(negedge clk);
        check("idle16", 32'({busy16, done16}), 32'd0);
    endtask

    task automatic do_add4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        logic [4:0] exp;
        int lat, bcnt;
        bit seen;
        exp = 5'(av) + 5'(bv) + 5'(cv);
        a4 = av; b4 = bv; c4 = cv; s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
        lat = -1; bcnt = 0; seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (busy4) bcnt++;
            if (done4) begin
                seen = 1'b1;
                lat  = k - 1;
            end else begin
                check("hold4", 32'({cout4, sum4}), 32'(last4));
            end
        end
        check("done4_seen", 32'(seen), 32'd1);
        check("lat4", 32'(lat), 32'd1);
        check("busy4_cycles", 32'(bcnt), 32'd2);
        check("sum4", 32'({cout4, sum4}), 32'(exp));
        last4 = exp;
        @(negedge clk);
        check("idle4", 32'({busy4, done4}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit [31:0] got_mask, exp_mask;
        int nf, ndone;
        logic [16:0] exp5;

        r16 = 1'b1; s16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
        r4  = 1'b1; s4  = 1'b0; a4  = '0; b4  = '0; c4  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        r16 = 1'b0; r4 = 1'b0;
        check("rst16", 32'({busy16, done16, cout16, sum16}), 32'd0);
        check("rst4", 32'({busy4, done4, cout4, sum4}), 32'd0);

        // T1, T2
        do_add16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_add16(16'h1234, 16'h4321, 1'b1, 1'b0);

        // T3: start pulse mid-run must not queue a second add
        do_add16(16'hA5A5, 16'h5A5B, 1'b0, 1'b1);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done16) ndone++;
        end
        check("t3_no_second_done", 32'(ndone), 32'd0);

        // T4: reset during run idx=1
        a16 = 16'h7777; b16 = 16'h8888; c16 = 1'b1; s16 = 1'b1;
        @(posedge clk); #1; s16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        r16 = 1'b1;
        @(posedge clk); #1; r16 = 1'b0;
        @(negedge clk);
        check("t4_after_reset", 32'({busy16, done16, cout16, sum16}), 32'd0);
        last16 = '0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done16) ndone++;
        end
        check("t4_no_done", 32'(ndone), 32'd0);
        do_add16(16'h0102, 16'h0304, 1'b0, 1'b0);

        // T5: start held for 20 edges; acceptance whenever the instance is idle
        exp5 = 17'h00FF + 17'h0F01 + 17'd1;
        a16 = 16'h00FF; b16 = 16'h0F01; c16 = 1'b1; s16 = 1'b1;
        got_mask = '0;
        for (int e = 0; e < 32; e++) begin
            @(posedge clk); #1;
            if (e == 19) s16 = 1'b0;
            @(negedge clk);
            if (done16) begin
                got_mask[e] = 1'b1;
                check("t5_sum", 32'({cout16, sum16}), 32'(exp5));
            end
        end
        exp_mask = '0;
        nf = 0;
        for (int e = 0; e < 20; e++) begin
            if (e >= nf) begin
                exp_mask[e + 4] = 1'b1;
                nf = e + 6;
            end
        end
        check("t5_done_mask", got_mask, exp_mask);
        last16 = exp5;

        // T6: random adds
        for (int i = 0; i < 175; i++)
            do_add16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        do_add4(4'hF, 4'h1, 1'b0);
        do_add4(4'h4, 4'h1, 1'b1);
        for (int i = 0; i < 20; i++)
            do_add4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
